// File: rtl/knn_insert_ctrl_pkg.sv
// knn_insert_ctrl_pkg
//   Shared definitions for the KNN insert controller and its datapath:
//   default K/N/IDX_W, the 3-bit binary state encoding, and a decoder for
//   the outputs that depend on state alone.
package knn_insert_ctrl_pkg;

  localparam int K_DEFAULT     = 4;
  localparam int N_DEFAULT     = 10;
  localparam int IDX_W_DEFAULT = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_INSERT = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  typedef struct packed {
    logic busy;
    logic nb_clr;
    logic dp_ready;
    logic en_nb;
    logic done;
  } moore_t;

  function automatic moore_t decode_moore(input state_t s);
    moore_t m;
    m          = '0;
    m.busy     = (s != S_IDLE);
    m.nb_clr   = (s == S_CLEAR);
    m.dp_ready = (s == S_LOAD);
    m.en_nb    = (s == S_INSERT);
    m.done     = (s == S_DONE);
    return m;
  endfunction

endpackage

// File: rtl/knn_insert_ctrl_pt_counter.sv
// knn_insert_ctrl_pt_counter
//   Point counter with synchronous clear, enable and terminal-count flag.
//   Ports:
//     clk, rst  clock, async active-low reset
//     clr       synchronous clear to 0 (wins over en)
//     en        increment by one
//     cnt       current count
//     tc        cnt == TC
module knn_insert_ctrl_pt_counter #(
  parameter int W  = 8,
  parameter int TC = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(TC));

endmodule

// File: rtl/knn_insert_ctrl.sv
// knn_insert_ctrl
//   Sequences the KNN distance/insert datapath for one test point over N
//   data points: accept a point, latch its distance, walk the K slots until
//   the comparator reports insert (or the last slot passes), then shift the
//   neighbour list. done pulses after the Nth point.
//
//   state  | meaning
//   IDLE   | waiting for start
//   CLEAR  | reset neighbour list and slot counter, zero pt_idx
//   LOAD   | dp_ready high, waiting for a data point
//   SCAN   | compare latched distance against slot cnt
//   INSERT | shift new neighbour in at current slot
//   NEXT   | count the point, pick LOAD or DONE
//   DONE   | one-cycle done pulse
//
//   Ports:
//     clk, rst                      clock, async active-low reset
//     start                         begin a test point (IDLE only)
//     dp_valid / dp_ready           data point handshake
//     insert, cnt_flag              comparator result, slot counter == K-1
//     nb_clr, en_dist, start_cnt,
//     inc_cnt, en_nb                datapath controls
//     busy, done, pt_idx            status
module knn_insert_ctrl
  import knn_insert_ctrl_pkg::*;
#(
  parameter int K     = K_DEFAULT,
  parameter int N     = N_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dp_valid,
  output logic             dp_ready,
  input  logic             insert,
  input  logic             cnt_flag,
  output logic             nb_clr,
  output logic             en_dist,
  output logic             start_cnt,
  output logic             inc_cnt,
  output logic             en_nb,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] pt_idx
);

  // K only sizes the datapath slot counter; it is checked here so a
  // mismatched instantiation is caught at elaboration.
  if (K < 1 || N < 1 || (64'd1 << IDX_W) <= 64'(N)) begin : g_bad_param
    $error("knn_insert_ctrl: need K>=1, N>=1 and 2**IDX_W > N");
  end

  state_t state;
  state_t state_nxt;
  moore_t mo;
  logic   last_pt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // en_dist/start_cnt follow dp_valid in LOAD so the distance is latched and
  // the slot counter zeroed on the accepting edge; SCAN then starts at slot 0.
  always_comb begin
    state_nxt = state;
    en_dist   = 1'b0;
    start_cnt = 1'b0;
    inc_cnt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        start_cnt = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (dp_valid) begin
          en_dist   = 1'b1;
          start_cnt = 1'b1;
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        // insert wins at the last slot; otherwise a point worse than all K
        // neighbours is dropped once cnt_flag is seen.
        if (insert) begin
          state_nxt = S_INSERT;
        end else if (cnt_flag) begin
          state_nxt = S_NEXT;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      S_INSERT: state_nxt = S_NEXT;
      S_NEXT:   state_nxt = last_pt ? S_DONE : S_LOAD;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign mo       = decode_moore(state);
  assign busy     = mo.busy;
  assign nb_clr   = mo.nb_clr;
  assign dp_ready = mo.dp_ready;
  assign en_nb    = mo.en_nb;
  assign done     = mo.done;

  knn_insert_ctrl_pt_counter #(
    .W  (IDX_W),
    .TC (N - 1)
  ) u_pt_counter (
    .clk (clk),
    .rst (rst),
    .clr (state == S_CLEAR),
    .en  (state == S_NEXT),
    .cnt (pt_idx),
    .tc  (last_pt)
  );

endmodule

// File: doc/knn_insert_ctrl.md
Name: knn_insert_ctrl

Overview:
- FSM that sequences the KNN distance/insert datapath for one test point over N data points.
- Per data point it:
  - accepts the point through a valid/ready handshake;
  - latches its distance (en_dist);
  - walks the K neighbour slots with the datapath slot counter until the comparator asserts insert or the last slot is reached;
  - pulses en_nb to shift in the new neighbour.
- Sits between the host/CPU register interface and the insert datapath. Signals done after N points.

Parameters:
- K, 4, number of neighbour slots (matches datapath K).
- N, 10, data points per test point; N >= 1.
- IDX_W, 8, width of pt_idx; must satisfy 2^IDX_W > N.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin classification of the current test point; sampled only in IDLE.
- dp_valid  in  1  data point and label valid on datapath inputs.
- dp_ready  out  1  controller accepts a data point this cycle.
- insert  in  1  datapath comparator: latched distance < distance in current slot.
- cnt_flag  in  1  datapath slot counter equals K-1.
- nb_clr  out  1  reset neighbour list to all-ones (maximum distance).
- en_dist  out  1  latch distance of the accepted point.
- start_cnt  out  1  reset slot counter to 0.
- inc_cnt  out  1  advance slot counter.
- en_nb  out  1  write/shift neighbour list at current slot.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the Nth point is processed.
- pt_idx  out  IDX_W  number of data points completed.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pt_idx=0, all 1-bit outputs 0.
  - Takes effect mid-operation with no drain. Datapath registers are not touched by the controller.
- States: IDLE, CLEAR, LOAD, SCAN, INSERT, NEXT, DONE.
- IDLE:
  - start=1 -> CLEAR. dp_valid is ignored.
- CLEAR (1 cycle):
  - nb_clr=1, start_cnt=1, pt_idx<=0 -> LOAD.
- LOAD:
  - dp_ready=1 (Moore).
  - If dp_valid=1: en_dist=1 and start_cnt=1 combinationally (Mealy, same cycle) -> SCAN. Otherwise stay.
- SCAN: comparator sees the latched distance vs slot cnt.
  - insert=1 -> INSERT, inc_cnt=0.
  - insert=0 & cnt_flag=1 -> NEXT (point discarded; worse than all K).
  - Otherwise inc_cnt=1, stay.
  - insert has priority over cnt_flag when both are high (insert at last slot).
- INSERT (1 cycle):
  - en_nb=1; slot counter holds -> NEXT.
- NEXT (1 cycle):
  - pt_idx<=pt_idx+1.
  - If pt_idx==N-1 -> DONE, else LOAD.
- DONE (1 cycle):
  - done=1 -> IDLE. start is ignored in this cycle.
- Latency, handshake accepted at cycle t, with slot j = first slot where insert=1:
  - next dp_ready at t+4+j.
  - No insert: next dp_ready at t+K+2.
  - Worst case K+3 cycles per point.
- start while busy=1 is ignored; in-flight operation is unaffected.
- Outputs other than en_dist, start_cnt and inc_cnt are decoded from state only.
- pt_idx holds its final value (N) in IDLE until the next CLEAR.
- Ties in distance are not inserted (strict comparator). The controller has no special handling.

Decomposition:
- Shared header knn_ctrl.vh holds:
  - state encoding localparams (3-bit binary);
  - default K/N.
- The datapath is shared via the same header.
- No sub-module required. The pt_idx counter is inline.
- Optional sub-module knn_pt_counter (enable/clear counter with terminal-count flag) if reused by the host interface.

Test Plan (K=4, N=3):
- Reset:
  - rst low mid-SCAN -> next cycle state IDLE, busy=0, pt_idx=0, all enables 0.
  - Release, start pulse -> nb_clr=1 for exactly one cycle, then dp_ready=1.
- Insert at slot 0 (model insert=1 immediately):
  - dp_valid at t -> en_dist=1 at t, en_nb=1 at t+2, dp_ready=1 at t+4.
- Insert at slot 2:
  - inc_cnt high at t+1 and t+2, en_nb at t+4, dp_ready at t+6.
- No insert:
  - cnt_flag=1 at 4th SCAN cycle, insert=0 -> no en_nb pulse, dp_ready at t+6, pt_idx increments.
- Full run of 3 points with dp_valid gaps of 2 cycles:
  - dp_ready held until accepted.
  - done pulses once, one cycle after the NEXT with pt_idx=2.
  - pt_idx=3 in IDLE.
- start asserted during SCAN and during DONE -> ignored; no extra nb_clr, and pt_idx is unchanged.
